// File: rtl/uart_fifo_wr_arbiter_pkg.sv
// uart_fifo_wr_arbiter_pkg: shared arbiter state type and pointer helper
package uart_fifo_wr_arbiter_pkg;
  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;
  function automatic int rr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/uart_fifo_wr_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr_i
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          any_o
);
  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_low;
  // Upper copy is unmasked, so the lowest set bit wraps around circularly.
  always_comb begin
    w_dbl = {req_i, req_i} & ({(2*N){1'b1}} << ptr_i);
    w_low = w_dbl & (~w_dbl + (2*N)'(1));
    gnt_o = w_low[N-1:0] | w_low[2*N-1:N];
    any_o = |req_i;
  end
endmodule

// File: rtl/uart_fifo_wr_arbiter.sv
// uart_fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port
module uart_fifo_wr_arbiter
  import uart_fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  arb_state_e r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt, w_rr_gnt;
  logic [PW-1:0] r_rr_ptr, w_rr_ptr_nxt, w_win_idx;
  logic [CW-1:0] r_beat_cnt, w_beat_cnt_nxt;
  logic w_any, w_own_valid, w_own_last, w_burst_end;
  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
    .req_i(req_valid_i),
    .ptr_i(r_rr_ptr),
    .gnt_o(w_rr_gnt),
    .any_o(w_any)
  );
  always_comb begin
    w_win_idx   = '0;
    fifo_data_o = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (w_rr_gnt[r]) w_win_idx = PW'(r);
      if (r_grant[r]) fifo_data_o = req_data_i[r*DATA_WIDTH +: DATA_WIDTH];
    end
  end
  // All outputs derive from the registered grant, so an idle grant forces them to zero.
  assign w_own_valid  = |(req_valid_i & r_grant);
  assign w_own_last   = |(req_last_i & r_grant);
  assign fifo_wr_en_o = w_own_valid & ~fifo_full_i;
  assign req_ready_o  = fifo_full_i ? '0 : r_grant;
  assign grant_o      = r_grant;
  assign busy_o       = (r_state == ARB_GRANT);
  assign w_burst_end  = w_own_last | (r_beat_cnt == CW'(MAX_BURST - 1));
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    if (r_state == ARB_IDLE) begin
      if (w_any) begin
        w_state_nxt    = ARB_GRANT;
        w_grant_nxt    = w_rr_gnt;
        w_rr_ptr_nxt   = PW'(rr_next(int'(w_win_idx), NUM_REQ));
        w_beat_cnt_nxt = '0;
      end
    end else if (!w_own_valid || (fifo_wr_en_o && w_burst_end)) begin
      w_state_nxt    = ARB_IDLE;
      w_grant_nxt    = '0;
      w_beat_cnt_nxt = '0;
    end else if (fifo_wr_en_o) begin
      w_beat_cnt_nxt = r_beat_cnt + CW'(1);
    end
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= ARB_IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end
  a_grant_onehot: assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(r_grant));
  a_no_wr_full: assert property (@(posedge clk_i) disable iff (reset_i) !(fifo_wr_en_o && fifo_full_i));
endmodule

// File: tb/tb_uart_fifo_wr_arbiter.sv
// tb_uart_fifo_wr_arbiter: directed and scoreboarded checks of the FIFO write arbiter
module tb_uart_fifo_wr_arbiter;
  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [3:0]  req_valid_i = '0;
  logic [3:0]  req_last_i = '0;
  logic [31:0] req_data_i = '0;
  logic [3:0]  req_ready_o;
  logic        fifo_full_i = 1'b0;
  logic        fifo_wr_en_o;
  logic [7:0]  fifo_data_o;
  logic [3:0]  grant_o;
  logic        busy_o;
  int checks = 0;
  int fails = 0;
  uart_fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .req_valid_i(req_valid_i),
    .req_last_i(req_last_i),
    .req_data_i(req_data_i),
    .req_ready_o(req_ready_o),
    .fifo_full_i(fifo_full_i),
    .fifo_wr_en_o(fifo_wr_en_o),
    .fifo_data_o(fifo_data_o),
    .grant_o(grant_o),
    .busy_o(busy_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic set_data(input int r, input logic [7:0] d);
    req_data_i[r*8 +: 8] = d;
  endtask
  task automatic do_reset();
    reset_i = 1'b1;
    req_valid_i = '0;
    req_last_i = '0;
    fifo_full_i = 1'b0;
    tick();
    reset_i = 1'b0;
  endtask
  task automatic check_idle_outputs(input string tag);
    check({tag, "_grant"}, 32'(grant_o), 0);
    check({tag, "_busy"}, 32'(busy_o), 0);
    check({tag, "_ready"}, 32'(req_ready_o), 0);
    check({tag, "_wr"}, 32'(fifo_wr_en_o), 0);
    check({tag, "_data"}, 32'(fifo_data_o), 0);
  endtask
  initial begin
    int seq [4];
    logic [3:0] acc;
    logic [3:0] e;
    int own;
    int writes;
    // 1: single requester, 3-beat packet
    tick();
    check_idle_outputs("rst");
    reset_i = 1'b0;
    tick();
    req_valid_i = 4'b0010;
    set_data(1, 8'h11);
    #1;
    check("t1_idle_grant", 32'(grant_o), 0);
    check("t1_idle_wr", 32'(fifo_wr_en_o), 0);
    tick();
    #1;
    check("t1_grant", 32'(grant_o), 4'b0010);
    check("t1_busy", 32'(busy_o), 1);
    check("t1_ready", 32'(req_ready_o), 4'b0010);
    check("t1_wr0", 32'(fifo_wr_en_o), 1);
    check("t1_data0", 32'(fifo_data_o), 8'h11);
    tick();
    set_data(1, 8'h12);
    #1;
    check("t1_wr1", 32'(fifo_wr_en_o), 1);
    check("t1_data1", 32'(fifo_data_o), 8'h12);
    tick();
    set_data(1, 8'h13);
    req_last_i = 4'b0010;
    #1;
    check("t1_wr2", 32'(fifo_wr_en_o), 1);
    check("t1_data2", 32'(fifo_data_o), 8'h13);
    tick();
    req_valid_i = '0;
    req_last_i = '0;
    #1;
    check("t1_end_grant", 32'(grant_o), 0);
    check("t1_end_busy", 32'(busy_o), 0);
    // 2: all requesting, bursts capped at 4 with one bubble
    do_reset();
    req_valid_i = 4'hF;
    for (int r = 0; r < 4; r++) set_data(r, 8'(8'hA0 + r));
    tick();
    for (int b = 0; b < 5; b++) begin
      e = 4'(1 << (b % 4));
      for (int k = 0; k < 4; k++) begin
        #1;
        check("t2_grant", 32'(grant_o), 32'(e));
        check("t2_wr", 32'(fifo_wr_en_o), 1);
        check("t2_data", 32'(fifo_data_o), 32'(8'hA0 + b % 4));
        tick();
      end
      #1;
      check("t2_bubble_wr", 32'(fifo_wr_en_o), 0);
      check("t2_bubble_grant", 32'(grant_o), 0);
      tick();
    end
    req_valid_i = '0;
    // 3: stall under full mid-burst
    do_reset();
    req_valid_i = 4'b0100;
    set_data(2, 8'h30);
    tick();
    #1;
    check("t3_grant", 32'(grant_o), 4'b0100);
    check("t3_data0", 32'(fifo_data_o), 8'h30);
    tick();
    set_data(2, 8'h31);
    fifo_full_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      #1;
      check("t3_stall_wr", 32'(fifo_wr_en_o), 0);
      check("t3_stall_ready", 32'(req_ready_o), 0);
      check("t3_stall_grant", 32'(grant_o), 4'b0100);
    end
    tick();
    fifo_full_i = 1'b0;
    #1;
    check("t3_resume_wr", 32'(fifo_wr_en_o), 1);
    check("t3_resume_data", 32'(fifo_data_o), 8'h31);
    tick();
    set_data(2, 8'h32);
    #1;
    check("t3_data2", 32'(fifo_data_o), 8'h32);
    tick();
    set_data(2, 8'h33);
    #1;
    check("t3_data3", 32'(fifo_data_o), 8'h33);
    check("t3_wr3", 32'(fifo_wr_en_o), 1);
    tick();
    #1;
    check("t3_cap_grant", 32'(grant_o), 0);
    req_valid_i = '0;
    // 4: owner drops valid, r3 takes over
    do_reset();
    req_valid_i = 4'b1001;
    set_data(0, 8'h40);
    set_data(3, 8'h43);
    tick();
    #1;
    check("t4_grant0", 32'(grant_o), 4'b0001);
    check("t4_data0", 32'(fifo_data_o), 8'h40);
    tick();
    req_valid_i = 4'b1000;
    #1;
    check("t4_drop_wr", 32'(fifo_wr_en_o), 0);
    tick();
    #1;
    check("t4_release", 32'(grant_o), 0);
    tick();
    #1;
    check("t4_grant3", 32'(grant_o), 4'b1000);
    check("t4_data3", 32'(fifo_data_o), 8'h43);
    req_last_i = 4'b1000;
    tick();
    req_valid_i = 4'hF;
    req_last_i = '0;
    #1;
    check("t4_end", 32'(grant_o), 0);
    tick();
    #1;
    check("t4_ptr0", 32'(grant_o), 4'b0001);
    req_valid_i = '0;
    tick();
    tick();
    // 5: asynchronous reset mid-burst
    req_valid_i = 4'b0100;
    set_data(2, 8'h50);
    tick();
    #1;
    check("t5_grant", 32'(grant_o), 4'b0100);
    tick();
    reset_i = 1'b1;
    #1;
    check_idle_outputs("t5_async");
    req_valid_i = 4'hF;
    tick();
    reset_i = 1'b0;
    tick();
    #1;
    check("t5_first", 32'(grant_o), 4'b0001);
    // 6: random scoreboard on per-requester ordered data
    do_reset();
    writes = 0;
    for (int r = 0; r < 4; r++) seq[r] = 0;
    for (int r = 0; r < 4; r++) begin
      req_valid_i[r] = ($urandom_range(0, 3) != 0);
      req_last_i[r] = ($urandom_range(0, 3) == 0);
      set_data(r, {2'(r), 6'(seq[r])});
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      #1;
      acc = req_valid_i & req_ready_o;
      check("rnd_accept", 32'(acc), fifo_wr_en_o ? 32'(grant_o) : 0);
      check("rnd_no_full_wr", 32'(fifo_wr_en_o & fifo_full_i), 0);
      check("rnd_onehot", 32'($onehot0(grant_o)), 1);
      if (fifo_wr_en_o) begin
        own = 0;
        for (int r = 0; r < 4; r++) if (grant_o[r]) own = r;
        check("rnd_data", 32'(fifo_data_o), 32'({2'(own), 6'(seq[own])}));
        writes++;
      end
      tick();
      for (int r = 0; r < 4; r++) begin
        if (acc[r]) seq[r]++;
        if (!req_valid_i[r] || acc[r]) begin
          req_valid_i[r] = ($urandom_range(0, 3) != 0);
          req_last_i[r] = ($urandom_range(0, 3) == 0);
          set_data(r, {2'(r), 6'(seq[r])});
        end
      end
      fifo_full_i = ($urandom_range(0, 4) == 0);
    end
    check("rnd_progress", 32'(writes > 500), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
